// File: rtl/sokoban_move_ctrl.sv
// sokoban_move_ctrl: accepts one direction command at a time, decides whether
// it is a walk, a push or illegal, and applies legal moves to the 8x8 board
// only during vertical blank so the renderer never sees a half-updated board.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a direction command (unless solved or loading)
// CHECK   | one cycle: evaluate walk / push legality of captured dir
// WAIT_VB | legal move pending, holding until vblank is high
// COMMIT  | one cycle: board, steps and win update on the exit edge
module sokoban_move_ctrl #(
  parameter int STEP_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [5:0]        lvl_man,
  input  logic [63:0]       lvl_box,
  input  logic [63:0]       lvl_wall,
  input  logic [63:0]       lvl_way,
  input  logic [63:0]       lvl_dst,
  input  logic              dir_valid,
  input  logic [1:0]        dir,
  output logic              dir_ready,
  input  logic              vblank,
  output logic [5:0]        man,
  output logic [63:0]       box,
  output logic [63:0]       wall,
  output logic [63:0]       way,
  output logic [63:0]       destination,
  output logic [STEP_W-1:0] steps,
  output logic              win,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, CHECK, WAIT_VB, COMMIT} state_t;

  state_t      state, state_nxt;
  logic [1:0]  dir_q;
  logic [5:0]  pend_man;
  logic [63:0] pend_box;

  logic [5:0]  t1, t2;
  logic        t1_off, t2_off;
  logic        t1_free, t2_free;
  logic        legal_walk, legal_push, legal;
  logic [63:0] push_box;
  logic        win_commit;
  logic        accept;

  // True when a move in direction d from cell c would leave the board.
  function automatic logic edge_blocked(input logic [5:0] c, input logic [1:0] d);
    case (d)
      2'd0:    edge_blocked = (c[5:3] == 3'd0);
      2'd1:    edge_blocked = (c[5:3] == 3'd7);
      2'd2:    edge_blocked = (c[2:0] == 3'd0);
      default: edge_blocked = (c[2:0] == 3'd7);
    endcase
  endfunction

  // Neighbouring cell index; only meaningful when edge_blocked is false.
  function automatic logic [5:0] step_cell(input logic [5:0] c, input logic [1:0] d);
    case (d)
      2'd0:    step_cell = c - 6'd8;
      2'd1:    step_cell = c + 6'd8;
      2'd2:    step_cell = c - 6'd1;
      default: step_cell = c + 6'd1;
    endcase
  endfunction

  // Target cells and their occupancy; t2 inherits off-board from t1.
  assign t1      = step_cell(man, dir_q);
  assign t2      = step_cell(t1, dir_q);
  assign t1_off  = edge_blocked(man, dir_q);
  assign t2_off  = t1_off | edge_blocked(t1, dir_q);
  assign t1_free = ~t1_off & ~wall[t1] & (way[t1] | destination[t1]) & ~box[t1];
  assign t2_free = ~t2_off & ~wall[t2] & (way[t2] | destination[t2]) & ~box[t2];

  assign legal_walk = t1_free;
  assign legal_push = ~t1_off & box[t1] & t2_free;
  assign legal      = legal_walk | legal_push;
  assign push_box   = (box & ~(64'd1 << t1)) | (64'd1 << t2);
  assign win_commit = (pend_box != 64'd0) && ((pend_box & ~destination) == 64'd0);

  assign dir_ready = (state == IDLE) & ~win & ~load;
  assign busy      = (state != IDLE);
  assign accept    = dir_valid & dir_ready;

  // State register; reset outranks load, load forces IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else if (load)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CHECK;
      CHECK:   state_nxt = legal ? WAIT_VB : IDLE;
      WAIT_VB: if (vblank) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Board, pending move, step counter and win flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      man         <= '0;
      box         <= '0;
      wall        <= '0;
      way         <= '0;
      destination <= '0;
      steps       <= '0;
      win         <= 1'b0;
      dir_q       <= '0;
      pend_man    <= '0;
      pend_box    <= '0;
    end else if (load) begin
      man         <= lvl_man;
      box         <= lvl_box;
      wall        <= lvl_wall;
      way         <= lvl_way;
      destination <= lvl_dst;
      steps       <= '0;
      win         <= 1'b0;
      pend_man    <= '0;
      pend_box    <= '0;
    end else begin
      if (state == IDLE && accept)
        dir_q <= dir;
      if (state == CHECK && legal) begin
        pend_man <= t1;
        pend_box <= legal_push ? push_box : box;
      end
      if (state == COMMIT) begin
        man <= pend_man;
        box <= pend_box;
        if (steps != {STEP_W{1'b1}})
          steps <= steps + STEP_W'(1);
        win <= win_commit;
      end
    end
  end

endmodule

// File: doc/sokoban_move_ctrl.md
# sokoban_move_ctrl

Move sequencer and owner of the 8×8 board state consumed by the mid-layer tile renderer. It accepts one direction command at a time and checks it against walls, boxes and board edges. Legal moves are committed only during vertical blank, so a frame never shows a half-updated board. It also loads levels, counts steps and flags completion.

## Interface
Parameters:
- STEP_W, 10, width of the step counter.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle pulse: copy lvl_* into board registers.
- lvl_man  in  6  level start cell, index {row[2:0],col[2:0]}.
- lvl_box, lvl_wall, lvl_way, lvl_dst  in  64 each  level bitmaps, bit i = cell i.
- dir_valid  in  1  direction command valid.
- dir  in  2  0=up(−8), 1=down(+8), 2=left(−1), 3=right(+1).
- dir_ready  out  1  command accepted on clk edge where dir_valid&dir_ready.
- vblank  in  1  level, high during vertical blanking.
- man  out  6  player cell.
- box, wall, way, destination  out  64 each  registered board bitmaps.
- steps  out  STEP_W  committed legal moves, saturating.
- win  out  1  all boxes on destinations.
- busy  out  1  high in CHECK, WAIT_VB and COMMIT.

## Operation
- States: IDLE, CHECK, WAIT_VB, COMMIT.
- dir_ready = (state==IDLE) & ~win & ~load.
- IDLE: on accept, capture dir and go to CHECK.
- CHECK (1 cycle):
  - t1 = man+delta; t2 = t1+delta.
  - A target is off-board if an up move starts in row 0, a down move starts in row 7, a left move starts in col 0, or a right move starts in col 7. Apply the same rule from t1 to get t2.
  - Cell c is free = on-board & ~wall[c] & (way[c]|destination[c]) & ~box[c].
  - Legal walk: t1 free. Go to WAIT_VB with pend_man=t1, pend_box=box.
  - Legal push: box[t1] & t2 free. Go to WAIT_VB with pend_man=t1, pend_box = box with bit t1 cleared and bit t2 set.
  - Otherwise the move is illegal: go to IDLE and change nothing.
- WAIT_VB: stay while vblank=0. On vblank=1, go to COMMIT.
- COMMIT (1 cycle): on the exit edge, update all of these, then go to IDLE:
  - man←pend_man, box←pend_box.
  - steps←steps+1, holding at all-ones.
  - win←(pend_box!=0) & ((pend_box & ~destination)==0).
- win=1 blocks commands until load or rst.
- load, from any state: on the next edge, board←lvl_*, steps←0, win←0, pending move discarded, state←IDLE.
  - load outranks an in-flight move and a same-cycle dir accept (dir_ready=0 while load=1).
- rst outranks load.
- wall, way and destination change only on load or rst.

## Timing
- Reset values:
  - man=0; box, wall, way, destination = 0; steps=0; win=0; busy=0.
  - state=IDLE, so dir_ready=1. An empty board makes every move illegal.
- Command accepted at edge E0: CHECK occupies E0–E1.
- Illegal move: dir_ready high again after edge E1. busy high for exactly 1 cycle.
- Legal move, vblank high during the E1–E2 cycle: COMMIT occupies E2–E3. man, box, steps and win change at E3. dir_ready returns after E3. This is the minimum latency of 3 edges.
- vblank low in WAIT_VB: commit stalls indefinitely. Outputs hold, dir_ready=0, busy=1.
- vblank dropping during COMMIT does not cancel the commit.
- Outputs are registered; no combinational path from inputs to board outputs.

## Test plan
- Level with a border wall, interior way, man=9, box bit 10, cell 11 free; dir=3 with vblank=1 → at edge E3: man=10, box bit 11 set, bit 10 clear, steps=1, win=0.
- man=9, wall bit 1, dir=0 → illegal: man=9, steps=0, busy high 1 cycle, dir_ready back after E1.
- Boxes at 10 and 11, man=9, dir=3 → illegal push, board unchanged. Separately, no walls, man=7, dir=3 → blocked by edge, man stays 7.
- Legal move with vblank held low 100 cycles → no output change, dir_ready=0, busy=1 throughout. Raise vblank → commit exactly 2 edges later.
- destination bit 11 with the only box at 10, push right → win=1 at E3. Further dir_valid pulses are ignored (dir_ready=0, steps stays 1). load pulse → win=0, steps=0, board = lvl_*.
- load asserted while in WAIT_VB → pending move discarded, board = lvl_*, state IDLE. steps set to 0xFFFF...-saturated preload, then another legal move → steps stays all-ones.
